adder_bist: RTL and testbench

//   Synthesizable built-in self-test for the WIDTH-bit ripple-carry adder. Generates the

---
 rtl/adder_bist_if.sv | 14 +
 rtl/adder_bist.sv | 154 +++++++++++++++
 tb/tb_adder_bist.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/adder_bist_if.sv
// Operand/result bus between the BIST controller and the adder it exercises.
// The master side drives the operands and the slave side returns {cout, s}.
interface adder_bist_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;

  modport master (output dut_a, output dut_b, output dut_cin, input dut_s, input dut_cout);
  modport slave  (input dut_a, input dut_b, input dut_cin, output dut_s, output dut_cout);
endinterface

// File: rtl/adder_bist.sv
// Exhaustive built-in self-test for a WIDTH-bit adder: sweeps b (inner), a, then cin,
// compares {cout,s} with a+b+cin and records the error count and first failing vector.
module adder_bist #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter bit SWEEP_CIN     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_bist_if.master         bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [WIDTH-1:0]     first_err_a,
  output logic [WIDTH-1:0]     first_err_b,
  output logic                 first_err_ci,
  output logic [WIDTH:0]       first_err_got
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int ERR_W = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [CNT_W-1:0]   r_settle;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [ERR_W-1:0]   r_err;
  logic [WIDTH-1:0]   r_fa;
  logic [WIDTH-1:0]   r_fb;
  logic               r_fci;
  logic [WIDTH:0]     r_fgot;

  logic [WIDTH:0]     w_exp;
  logic [WIDTH:0]     w_got;
  logic               w_mismatch;
  logic [ERR_W-1:0]   w_err_next;
  logic               w_last;

  assign w_exp      = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_got      = {bus.dut_cout, bus.dut_s};
  assign w_mismatch = (w_got != w_exp);
  assign w_last     = (&r_a) && (&r_b) && (r_cin == SWEEP_CIN);

  // Saturating error counter increment for the vector being sampled.
  always_comb begin
    w_err_next = r_err;
    if (w_mismatch && !(&r_err)) begin
      w_err_next = r_err + ERR_W'(1);
    end else begin
      w_err_next = r_err;
    end
  end

  // Sweep controller: operand generation, settle timing, checking and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_cin    <= 1'b0;
      r_settle <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= {ERR_W{1'b0}};
      r_fa     <= {WIDTH{1'b0}};
      r_fb     <= {WIDTH{1'b0}};
      r_fci    <= 1'b0;
      r_fgot   <= {(WIDTH+1){1'b0}};
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= DRIVE;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_cin    <= 1'b0;
            r_settle <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= {ERR_W{1'b0}};
            r_fa     <= {WIDTH{1'b0}};
            r_fb     <= {WIDTH{1'b0}};
            r_fci    <= 1'b0;
            r_fgot   <= {(WIDTH+1){1'b0}};
          end else begin
            r_state <= r_state;
          end
        end
        DRIVE: begin
          if (r_settle == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_settle <= {CNT_W{1'b0}};
            r_state  <= SAMPLE;
          end else begin
            r_settle <= r_settle + CNT_W'(1);
          end
        end
        SAMPLE: begin
          r_err <= w_err_next;
          // A zero count means no earlier mismatch, since saturation never returns to zero.
          if (w_mismatch && (r_err == {ERR_W{1'b0}})) begin
            r_fa   <= r_a;
            r_fb   <= r_b;
            r_fci  <= r_cin;
            r_fgot <= w_got;
          end
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == {ERR_W{1'b0}});
          end else begin
            r_state <= DRIVE;
            r_b     <= r_b + WIDTH'(1);
            if (&r_b) begin
              r_a <= r_a + WIDTH'(1);
              if ((&r_a) && SWEEP_CIN && !r_cin) begin
                r_cin <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.dut_a     = r_a;
  assign bus.dut_b     = r_b;
  assign bus.dut_cin   = r_cin;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_a   = r_fa;
  assign first_err_b   = r_fb;
  assign first_err_ci  = r_fci;
  assign first_err_got = r_fgot;
endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist at WIDTH=4, SETTLE_CYCLES=2, SWEEP_CIN=1 with a fault-injectable
// adder model; fixed-fault table plus randomized faults scored by a sweep reference model.
module tb_adder_bist;
  localparam int W       = 4;
  localparam int S       = 2;
  localparam bit SC      = 1'b1;
  localparam int VECS    = (1 << (2 * W)) * (SC ? 2 : 1);
  localparam int RUNLEN  = VECS * (S + 1) + 1;
  localparam int LIMIT   = RUNLEN + 100;

  logic clk;
  logic rst;
  logic start;
  logic busy, done, pass;
  logic [2*W+1:0] err_count;
  logic [W-1:0]   first_err_a, first_err_b;
  logic           first_err_ci;
  logic [W:0]     first_err_got;

  int mode;
  int f1, f2;
  logic [W:0] fmask;
  int checks;
  int failures;

  adder_bist_if #(.WIDTH(W)) bus ();

  adder_bist #(.WIDTH(W), .SETTLE_CYCLES(S), .SWEEP_CIN(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_a(first_err_a), .first_err_b(first_err_b),
    .first_err_ci(first_err_ci), .first_err_got(first_err_got)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test with selectable faults.
  function automatic logic [W:0] adder_fn(input int md, input int a, input int b, input int ci);
    logic [W:0] r;
    r = (W+1)'(a + b + ci);
    case (md)
      1: if (a == 3 && b == 5) r[0] = ~r[0];
      2: r[W] = 1'b0;
      3: if ((ci * 256 + a * 16 + b) == f1 || (ci * 256 + a * 16 + b) == f2) r = r ^ fmask;
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    {bus.dut_cout, bus.dut_s} = adder_fn(mode, int'(bus.dut_a), int'(bus.dut_b), int'(bus.dut_cin));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: walk the sweep in order and score every vector with plain arithmetic.
  task automatic model(input int md, output int e, output int fa, output int fb,
                       output int fci, output int fgot);
    int got;
    e = 0; fa = 0; fb = 0; fci = 0; fgot = 0;
    for (int ci = 0; ci <= int'(SC); ci++)
      for (int a = 0; a < (1 << W); a++)
        for (int b = 0; b < (1 << W); b++) begin
          got = int'(adder_fn(md, a, b, ci));
          if (got != a + b + ci) begin
            if (e == 0) begin fa = a; fb = b; fci = ci; fgot = got; end
            e++;
          end
        end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, bus.dut_a, 0);
    chk({tag, "_b"}, bus.dut_b, 0);
    chk({tag, "_cin"}, bus.dut_cin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fa"}, first_err_a, 0);
    chk({tag, "_fb"}, first_err_b, 0);
    chk({tag, "_fci"}, first_err_ci, 0);
    chk({tag, "_fgot"}, first_err_got, 0);
  endtask

  task automatic run(input string tag, input bit mid_start, input int e, input int fa,
                     input int fb, input int fci, input int fgot);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_done_drop"}, done, 0);
    while (!done && n < LIMIT) begin
      if (mid_start && n == 100) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, "_runlen"}, n, RUNLEN);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_pass"}, pass, (e == 0) ? 1 : 0);
    chk({tag, "_err"}, err_count, e);
    chk({tag, "_fa"}, first_err_a, fa);
    chk({tag, "_fb"}, first_err_b, fb);
    chk({tag, "_fci"}, first_err_ci, fci);
    chk({tag, "_fgot"}, first_err_got, fgot);
    chk({tag, "_hold_a"}, bus.dut_a, (1 << W) - 1);
    chk({tag, "_hold_b"}, bus.dut_b, (1 << W) - 1);
    chk({tag, "_hold_cin"}, bus.dut_cin, SC);
  endtask

  typedef struct {
    int md; int e; int fa; int fb; int fci; int fgot; bit mid;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int e, fa, fb, fci, fgot;
    checks = 0; failures = 0;
    mode = 0; f1 = -1; f2 = -1; fmask = '0;
    rst = 1'b1; start = 1'b0;

    tbl[0] = '{0, 0,   0, 0,  0, 0,  1'b1};
    tbl[1] = '{1, 2,   3, 5,  0, 9,  1'b0};
    tbl[2] = '{2, 256, 1, 15, 0, 0,  1'b0};
    tbl[3] = '{0, 0,   0, 0,  0, 0,  1'b0};

    // Simultaneous rst and start: reset wins.
    start = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    check_zero("reset");
    tick();
    chk("idle_after_reset_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].md;
      run($sformatf("tbl%0d", i), tbl[i].mid, tbl[i].e, tbl[i].fa, tbl[i].fb,
          tbl[i].fci, tbl[i].fgot);
    end

    for (int k = 0; k < 4; k++) begin
      mode  = 3;
      f1    = int'($urandom_range(0, VECS - 1));
      f2    = int'($urandom_range(0, VECS - 1));
      fmask = (W+1)'($urandom_range(1, (1 << (W + 1)) - 1));
      model(3, e, fa, fb, fci, fgot);
      run($sformatf("rand%0d", k), 1'b0, e, fa, fb, fci, fgot);
    end

    // Reset in the middle of a run with errors already recorded.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 400; n++) tick();
    chk("midrun_busy", busy, 1);
    chk("midrun_err_nonzero", (err_count != 0) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midrun_rst");
    tick(); tick();
    chk("midrun_idle_busy", busy, 0);

    mode = 0;
    run("after_rst", 1'b0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
